// File: rtl/adc_acq_pkg.sv
// Shared types and default parameters for the multi-lane serial ADC acquisition sequencer.
package adc_acq_pkg;

    localparam int DEF_NUM_LANES   = 8;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_CNV_PULSE   = 4;
    localparam int DEF_CONV_CYCLES = 90;
    localparam int DEF_SCLK_DIV    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/adc_acq_sequencer_sclk_gen.sv
// SCLK divider: toggles sclk every SCLK_DIV cycles while run is high, starting low,
// and flags the clk edge at which sclk will rise or fall.
module sclk_gen #(
    parameter int SCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             terminal;

    assign terminal = run && (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign rise     = terminal && !sclk;
    assign fall     = terminal && sclk;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (terminal) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_acq_sequencer.sv
// Runs one CNV / conversion-wait / SCLK-burst readout per accepted trigger and publishes
// all lanes at once, holding a level 'done' until the next accepted trigger.
module adc_acq_sequencer
    import adc_acq_pkg::*;
#(
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CNV_PULSE   = DEF_CNV_PULSE,
    parameter int CONV_CYCLES = DEF_CONV_CYCLES,
    parameter int SCLK_DIV    = DEF_SCLK_DIV
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        trigger,
    input  logic                        enable,
    input  logic [NUM_LANES-1:0]        adc_sdo,
    output logic                        adc_cnv,
    output logic                        adc_sclk,
    output logic [NUM_LANES*DATA_W-1:0] data_out,
    output logic                        data_valid,
    output logic                        done,
    output logic                        busy,
    output logic                        overrun
);

    localparam int CONV_W = $clog2(CONV_CYCLES + 1);
    localparam int BIT_W  = $clog2(DATA_W + 1);

    state_t                               state;
    logic [CONV_W-1:0]                    conv_cnt;
    logic [BIT_W-1:0]                     bit_cnt;
    logic                                 sclk_rise;
    logic                                 sclk_fall;
    logic [NUM_LANES-1:0][DATA_W-1:0]     lane_word;

    assign busy = (state == CONVERT) || (state == SHIFT);

    sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state == SHIFT),
        .sclk  (adc_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Lane capture happens on the clk edge where SCLK rises, MSB first.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [DATA_W-1:0] shreg;

        // NOTE: shift registers are reset too, so a reset can never leave partial data to publish.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                shreg <= '0;
            else if (sclk_rise)
                shreg <= {shreg[DATA_W-2:0], adc_sdo[i]};
        end

        assign lane_word[i] = shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            conv_cnt   <= '0;
            bit_cnt    <= '0;
            adc_cnv    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            overrun    <= trigger && enable && busy;
            case (state)
                IDLE, DONE: begin
                    if (trigger && enable) begin
                        state    <= CONVERT;
                        conv_cnt <= '0;
                        adc_cnv  <= 1'b1;
                        done     <= 1'b0;
                    end else if (!enable) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                CONVERT: begin
                    // Registered so the CNV line to the ADC is glitch-free.
                    adc_cnv <= (int'(conv_cnt) + 1) < CNV_PULSE;
                    if (conv_cnt == CONV_W'(CONV_CYCLES - 1)) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (sclk_rise && bit_cnt != BIT_W'(DATA_W))
                        bit_cnt <= bit_cnt + 1'b1;
                    // Finish on the falling edge after the last bit so SCLK is parked low.
                    if (sclk_fall && bit_cnt == BIT_W'(DATA_W)) begin
                        state      <= DONE;
                        data_out   <= lane_word;
                        data_valid <= 1'b1;
                        done       <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed bench for adc_acq_sequencer: table of acquisitions against a serial ADC model,
// plus hand sequences for reset, disabled triggers and mid-shift reset.
module tb_adc_acq_sequencer;

    localparam int NL      = 8;
    localparam int DW      = 16;
    localparam int LATENCY = 154;   // done set at edge k+154, first sampled high at edge k+155

    typedef struct {
        logic [DW-1:0] base;         // lane i carries base + i
        int            extra_at;     // cycle offset of a second trigger, 0 = none
        int            drop_at;      // cycle offset where enable drops, 0 = never
        int            gap;          // idle cycles after done before the next stimulus
        int            exp_overrun;
        logic          exp_hold;     // done still high one cycle after it rose
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 trigger = 1'b0;
    logic                 enable = 1'b0;
    logic [NL-1:0]        adc_sdo;
    logic                 adc_cnv, adc_sclk, data_valid, done, busy, overrun;
    logic [NL*DW-1:0]     data_out;

    int                   errors = 0;
    int                   checks = 0;
    int                   nrise = 0;
    logic [DW-1:0]        model_base = '0;
    vec_t                 vecs [5];

    always #5 clk = ~clk;

    adc_acq_sequencer #(
        .NUM_LANES   (NL),
        .DATA_W      (DW),
        .CNV_PULSE   (4),
        .CONV_CYCLES (90),
        .SCLK_DIV    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger    (trigger),
        .enable     (enable),
        .adc_sdo    (adc_sdo),
        .adc_cnv    (adc_cnv),
        .adc_sclk   (adc_sclk),
        .data_out   (data_out),
        .data_valid (data_valid),
        .done       (done),
        .busy       (busy),
        .overrun    (overrun)
    );

    // ADC model: a CNV pulse restarts the word, each SCLK rise consumes one bit MSB first.
    always @(posedge adc_cnv) nrise <= 0;
    always @(posedge adc_sclk) nrise <= nrise + 1;

    always_comb begin
        logic [DW-1:0] w;
        w = '0;
        adc_sdo = '0;
        for (int i = 0; i < NL; i++) begin
            w = model_base + DW'(i);
            if (nrise < DW)
                adc_sdo[i] = w[DW-1-nrise];
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " adc_cnv"}, adc_cnv, 0);
        check({tag, " adc_sclk"}, adc_sclk, 0);
        check({tag, " data_out"}, data_out, 0);
        check({tag, " data_valid"}, data_valid, 0);
        check({tag, " done"}, done, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " overrun"}, overrun, 0);
    endtask

    task automatic run_acq(input vec_t v, input string tag);
        int               cnv_cnt;
        int               ov_cnt;
        int               dv_cnt;
        int               lat;
        logic [NL*DW-1:0] exp_data;
        model_base = v.base;
        for (int i = 0; i < NL; i++)
            exp_data[i*DW +: DW] = v.base + DW'(i);
        trigger = 1'b1;
        enable  = 1'b1;
        tick();
        trigger = 1'b0;
        check({tag, " done cleared on accept"}, done, 0);
        check({tag, " busy on accept"}, busy, 1);
        cnv_cnt = int'(adc_cnv);
        ov_cnt  = int'(overrun);
        dv_cnt  = int'(data_valid);
        lat     = -1;
        for (int n = 1; n <= 300 && lat < 0; n++) begin
            trigger = (n == v.extra_at);
            if (v.drop_at != 0 && n >= v.drop_at)
                enable = 1'b0;
            tick();
            trigger = 1'b0;
            cnv_cnt += int'(adc_cnv);
            ov_cnt  += int'(overrun);
            dv_cnt  += int'(data_valid);
            if (done)
                lat = n;
        end
        check({tag, " done latency"}, lat, LATENCY);
        check({tag, " cnv high cycles"}, cnv_cnt, 4);
        check({tag, " sclk rises"}, nrise, DW);
        check({tag, " data_out"}, data_out, exp_data);
        check({tag, " data_valid at done"}, data_valid, 1);
        check({tag, " data_valid pulses"}, dv_cnt, 1);
        check({tag, " overrun pulses"}, ov_cnt, v.exp_overrun);
        check({tag, " busy at done"}, busy, 0);
        check({tag, " sclk parked low"}, adc_sclk, 0);
        for (int g = 0; g < v.gap; g++) begin
            tick();
            if (g == 0) begin
                check({tag, " data_valid one cycle"}, data_valid, 0);
                check({tag, " done after one cycle"}, done, v.exp_hold);
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        int   seen_busy;
        int   seen_cnv;
        int   seen_ov;
        vec_t v_rst;

        vecs[0] = '{16'hA5A0,   0,  0, 3, 0, 1'b1};  // basic acquisition, A5A0+i per lane
        vecs[1] = '{16'h0000,  50,  0, 3, 1, 1'b1};  // second trigger mid-CONVERT
        vecs[2] = '{16'hFFF0,   0, 20, 3, 0, 1'b0};  // enable dropped mid-CONVERT
        vecs[3] = '{16'h5A5A, 154,  0, 1, 1, 1'b1};  // trigger on the final SHIFT cycle
        vecs[4] = '{16'h3C3C,   0,  0, 2, 0, 1'b1};  // back-to-back after vecs[3]
        v_rst   = '{16'h0F0F,   0,  0, 2, 0, 1'b1};

        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Trigger while disabled must be ignored without overrun.
        seen_busy = 0;
        seen_cnv  = 0;
        seen_ov   = 0;
        enable  = 1'b0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int t = 0; t < 5; t++) begin
            seen_busy += int'(busy);
            seen_cnv  += int'(adc_cnv);
            seen_ov   += int'(overrun);
            tick();
        end
        check("disabled busy", seen_busy, 0);
        check("disabled cnv", seen_cnv, 0);
        check("disabled overrun", seen_ov, 0);
        check("disabled done", done, 0);

        for (int k = 0; k < 5; k++)
            run_acq(vecs[k], $sformatf("vec%0d", k));

        // Asynchronous reset in the middle of the SCLK burst.
        model_base = 16'h1111;
        enable  = 1'b1;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        for (int t = 0; t < 200 && nrise < 7; t++)
            tick();
        check("midshift reached bit 7", nrise, 7);
        rst_n = 1'b0;
        #1;
        check_all_zero("midshift async reset");
        tick();
        tick();
        check("midshift data_out held 0", data_out, 0);
        check("midshift data_valid held 0", data_valid, 0);
        rst_n = 1'b1;
        tick();
        run_acq(v_rst, "post reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
